// File: rtl/rv64_pkg.sv
// Shared RV64 core constants and write-back request type.
package rv64_pkg;
  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin grant; grants are combinational, last grant is registered.
module wb_rr_arbiter
  import rv64_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);
  grant_e last_grant;

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        a_grant = (last_grant == GNT_B);
        b_grant = (last_grant == GNT_A);
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  // A grant always implies a transfer, since grant requires valid.
  always_ff @(posedge clk) begin
    if (rst)          last_grant <= GNT_A;
    else if (a_grant) last_grant <= GNT_A;
    else if (b_grant) last_grant <= GNT_B;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load/multi-cycle results onto one register-file write port
// and tracks outstanding destinations in a pending scoreboard.
module writeback_arbiter
  import rv64_pkg::*;
#(
  parameter int XLEN = rv64_pkg::XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic [NUM_REGS-1:0]   pending
);
  wb_req_t             sel;
  logic [1:0]          vld_pipe;
  logic [NUM_REGS-1:0] pend_nxt;

  wb_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_grant (a_ready),
    .b_grant (b_ready)
  );

  always_comb begin
    sel = '0;
    if (a_ready)      sel = '{valid: 1'b1, rd: a_rd, data: a_data};
    else if (b_ready) sel = '{valid: 1'b1, rd: b_rd, data: b_data};
  end

  // x0 writes complete the handshake but never reach the register file.
  assign vld_pipe[0] = sel.valid && (sel.rd != '0);
  assign wb_we       = vld_pipe[1];

  // Set is applied after clear so a newly issued producer keeps ownership.
  always_comb begin
    pend_nxt = pending;
    if (vld_pipe[0])                        pend_nxt[sel.rd]   = 1'b0;
    if (issue_valid && (issue_rd != '0))    pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe[1] <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      pending     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (sel.valid) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
      pending <= pend_nxt;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed + random bench for writeback_arbiter with an expected-write queue.
module tb_writeback_arbiter;
  import rv64_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, issue_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, issue_rd;
  logic [63:0] a_data, b_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [31:0] pending;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .pending(pending)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
    bit          known;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  bit          lg;          // 0 = A granted last
  logic [31:0] m_pend;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  bit          m_known;
  bit          last_ar, last_br;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; check readies, predict, clock once, compare.
  task automatic tick();
    bit          ear, ebr;
    logic [4:0]  rd;
    logic [63:0] data;
    exp_t        e;
    #1;
    if (rst) begin
      ear = 1'b0; ebr = 1'b0;
    end else if (a_valid && b_valid) begin
      ear = lg; ebr = !lg;
    end else begin
      ear = a_valid; ebr = b_valid;
    end
    chk("a_ready", a_ready, ear);
    chk("b_ready", b_ready, ebr);
    last_ar = ear; last_br = ebr;
    e = '{we: 1'b0, rd: 5'd0, data: 64'd0, known: 1'b1};
    if (rst) begin
      lg = 1'b0; m_pend = '0; m_rd = '0; m_data = '0; m_known = 1'b1;
    end else begin
      rd   = ear ? a_rd : b_rd;
      data = ear ? a_data : b_data;
      if (ear || ebr) begin
        lg = ebr;
        if (rd != 0) begin
          m_pend[rd] = 1'b0;
          e.we = 1'b1;
          m_rd = rd; m_data = data; m_known = 1'b1;
        end else begin
          m_known = 1'b0;   // address/data latched for x0 is not observable
        end
      end
      if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      e.rd = m_rd; e.data = m_data; e.known = m_known;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("wb_we", wb_we, e.we);
    if (e.known) begin
      chk("wb_rd", wb_rd, e.rd);
      chk("wb_data", wb_data, e.data);
    end
    chk("pending", pending, m_pend);
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; issue_valid = 0;
    a_rd = 0; b_rd = 0; issue_rd = 0; a_data = 0; b_data = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #1;
    tick();
    chk("reset_pending", pending, 32'd0);
    chk("reset_wb_we", wb_we, 1'b0);
    rst = 0;

    // single ALU write
    a_valid = 1; a_rd = 5; a_data = 64'h1234;
    tick();
    chk("r036_we", wb_we, 1'b1);
    chk("r036_rd", wb_rd, 5'd5);
    chk("r036_data", wb_data, 64'h1234);
    idle_inputs();
    tick();
    chk("r036_idle_we", wb_we, 1'b0);

    // contention after reset: B first, then alternate, no gaps
    rst = 1; tick(); rst = 0;
    a_valid = 1; a_rd = 1; a_data = 64'hAAAA;
    b_valid = 1; b_rd = 2; b_data = 64'hBBBB;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("r037_we", wb_we, 1'b1);
      chk("r037_rd", wb_rd, (i % 2 == 0) ? 5'd2 : 5'd1);
    end
    idle_inputs();
    tick();

    // issue then late completion
    issue_valid = 1; issue_rd = 7;
    tick();
    chk("r038_set", pending[7], 1'b1);
    idle_inputs();
    tick();
    chk("r038_hold", pending[7], 1'b1);
    b_valid = 1; b_rd = 7; b_data = 64'h77;
    tick();
    chk("r038_clr", pending[7], 1'b0);
    idle_inputs();

    // same-cycle set and clear: set wins
    issue_valid = 1; issue_rd = 9;
    a_valid = 1; a_rd = 9; a_data = 64'h99;
    tick();
    chk("r039_pend", pending[9], 1'b1);
    chk("r039_we", wb_we, 1'b1);
    chk("r039_rd", wb_rd, 5'd9);
    idle_inputs();

    // x0 write
    a_valid = 1; a_rd = 0; a_data = 64'hFF;
    tick();
    chk("r040_we", wb_we, 1'b0);
    chk("r040_pend9", pending[9], 1'b1);
    idle_inputs();

    // reset during a transfer
    issue_valid = 1; issue_rd = 3;
    tick();
    chk("r041_pre", pending[3], 1'b1);
    idle_inputs();
    a_valid = 1; a_rd = 3; a_data = 64'h33; b_valid = 1; b_rd = 4;
    rst = 1;
    tick();
    chk("r041_we", wb_we, 1'b0);
    chk("r041_pend", pending, 32'd0);
    rst = 0;
    idle_inputs();
    tick();

    // random traffic, holding a stalled producer stable
    for (int i = 0; i < 60; i++) begin
      if (!(a_valid && !last_ar)) begin
        a_valid = 1'($urandom_range(0, 1));
        a_rd = 5'($urandom_range(0, 31)); a_data = {$urandom, $urandom};
      end
      if (!(b_valid && !last_br)) begin
        b_valid = 1'($urandom_range(0, 1));
        b_rd = 5'($urandom_range(0, 31)); b_data = {$urandom, $urandom};
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 31));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of write-back results.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 a_valid  in  1  ALU result valid.
REQ-005 a_ready  out  1  ALU result accepted this cycle.
REQ-006 a_rd  in  5  ALU destination register.
REQ-007 a_data  in  XLEN  ALU result.
REQ-008 b_valid  in  1  load/multi-cycle result valid.
REQ-009 b_ready  out  1  load/multi-cycle result accepted this cycle.
REQ-010 b_rd  in  5  load/multi-cycle destination register.
REQ-011 b_data  in  XLEN  load/multi-cycle result.
REQ-012 issue_valid  in  1  instruction with destination issued this cycle.
REQ-013 issue_rd  in  5  destination of the issued instruction.
REQ-014 wb_we  out  1  register-file write enable.
REQ-015 wb_rd  out  5  register-file write address.
REQ-016 wb_data  out  XLEN  register-file write data.
REQ-017 pending  out  32  scoreboard; bit i = register i awaits write-back.

Function
REQ-018 Handshake: transfer on a port when valid and ready are both high in the same cycle; the producer holds rd/data stable while valid and not ready.
REQ-019 At most one of a_ready, b_ready is high per cycle; ready depends only on both valid inputs and the last-grant state, never on wb_* outputs.
REQ-020 Only one port valid -> that port is granted (ready high) in the same cycle.
REQ-021 Both valid -> round-robin: grant the port not granted last; last_grant resets to A, so the first contended cycle grants B.
REQ-022 last_grant updates only on a transfer; it holds when no port transfers.
REQ-023 Output stage is registered, latency 1: a transfer in cycle N drives wb_rd/wb_data in cycle N+1, with wb_we=1 unless rd==0.
REQ-024 Cycle without a transfer -> wb_we=0 next cycle; wb_rd/wb_data hold their previous values.
REQ-025 Transfer with rd==0 completes the handshake but produces wb_we=0 and does not touch pending.
REQ-026 pending set: issue_valid with issue_rd!=0 sets bit issue_rd at next edge.
REQ-027 pending clear: a transfer with rd!=0 clears bit rd at next edge.
REQ-028 Same-cycle set and clear of the same register -> set wins (the newer producer owns it).
REQ-029 pending[0] is constant 0.
REQ-030 Throughput: one write-back per cycle sustained; no bubble between back-to-back grants.

Reset
REQ-031 rst high at a clock edge -> wb_we=0, wb_rd=0, wb_data=0, pending=0, last_grant=A next cycle, regardless of inputs.
REQ-032 a_ready and b_ready are 0 in any cycle with rst high; no transfer occurs.
REQ-033 Reset asserted mid-stream discards the granted result; no write is produced for it.

Structure
REQ-034 XLEN default, REG_ADDR_W=5 and NUM_REGS=32 belong in the shared rv64_pkg package, together with a wb_req_t struct (valid, rd, data).
REQ-035 The two-way round-robin grant logic is a sub-module named wb_rr_arbiter.

Verification
REQ-036 a_valid=1, a_rd=5, a_data=0x1234 for one cycle, b idle -> a_ready=1 same cycle; next cycle wb_we=1, wb_rd=5, wb_data=0x1234.
REQ-037 a and b valid for 4 cycles (a_rd=1, b_rd=2) after reset -> grants B,A,B,A; wb_rd sequence 2,1,2,1 with no gaps.
REQ-038 issue_valid with issue_rd=7, then b transfer to rd=7 two cycles later -> pending[7] is 1 for two cycles, then 0.
REQ-039 issue_rd=9 and a transfer to rd=9 in the same cycle -> pending[9]=1 afterwards, wb_we=1, wb_rd=9.
REQ-040 a transfer with a_rd=0, a_data=0xFF -> a_ready=1; wb_we stays 0; pending unchanged.
REQ-041 rst asserted in the cycle a transfer to rd=3 occurs, with pending[3]=1 -> next cycle wb_we=0, pending=0, a_ready=b_ready=0 while rst is high.
